// File: rtl/core_pkg.sv
// Shared types and constants for the core pipeline.
package core_pkg;

  // addi x0,x0,0 -- the canonical bubble encoding
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Fetch controller states (2-bit encoding, value 3 unused)
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } fetch_state_e;

  // Contents of a fetch/decode pipeline register
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
  } ifid_reg_t;

  // Sequential PC step; wraps modulo 2^32
  function automatic logic [31:0] pc_step(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/ifid_reg.sv
// Pipeline register with clear-over-write priority. Clear inserts a bubble and
// keeps the PC; a write of an invalid entry also yields a bubble and keeps the PC.
module ifid_reg
  import core_pkg::*;
#(
  parameter logic [31:0] BUBBLE_INSTR = NOP_INSTR
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      clear,
  input  logic      wren,
  input  ifid_reg_t d,
  output ifid_reg_t q
);

  ifid_reg_t q_reg;

  // Register update: clear beats write, otherwise hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_reg.pc    <= 32'd0;
      q_reg.instr <= BUBBLE_INSTR;
      q_reg.valid <= 1'b0;
    end else if (clear) begin
      q_reg.valid <= 1'b0;
      q_reg.instr <= BUBBLE_INSTR;
    end else if (wren) begin
      q_reg.valid <= d.valid;
      q_reg.instr <= d.valid ? d.instr : BUBBLE_INSTR;
      if (d.valid) begin
        q_reg.pc <= d.pc;
      end
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/ifu_fetch_stage.sv
// Instruction fetch stage: owns the PC, keeps one instruction-memory request
// outstanding at most, buffers one returned instruction and feeds IF/ID.
module ifu_fetch_stage
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        pc_wren_i,
  input  logic        IFID_wren_i,
  input  logic        IFID_clear_i,
  input  logic        br_flush_i,
  input  logic [31:0] br_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] IFID_pc_o,
  output logic [31:0] IFID_pc4_o,
  output logic [31:0] IFID_instr_o,
  output logic        IFID_valid_o,
  output logic        fetch_busy_o
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q;
  logic [31:0]  fetch_pc;
  logic         hold_valid;
  logic [31:0]  hold_instr;
  logic [31:0]  hold_pc;
  logic         issue;
  logic         busy;
  logic         consume;
  logic         refill;
  ifid_reg_t    ifid_d, ifid_q;

  // The decode stage takes the buffered instruction this cycle
  assign consume = IFID_wren_i & ~IFID_clear_i & hold_valid;

  // A response lands in the buffer only if no redirect kills it
  assign refill = (state_q == S_WAIT) & imem_rvalid_i & ~br_flush_i;

  // Next-state and request decode
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    busy    = 1'b0;
    case (state_q)
      S_IDLE: begin
        // rst_ni gating keeps the request low for the whole reset interval
        if (rst_ni && pc_wren_i && !br_flush_i && (!hold_valid || consume)) begin
          issue   = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        busy = 1'b1;
        if (br_flush_i) begin
          state_d = imem_rvalid_i ? S_IDLE : S_DROP;
        end else if (imem_rvalid_i) begin
          state_d = S_IDLE;
        end
      end
      S_DROP: begin
        busy = 1'b1;
        // A further flush does not change anything here; the stale response
        // still retires the outstanding request so the fetcher cannot lock up.
        if (imem_rvalid_i) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // PC and address of the outstanding request; redirect beats stall
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q     <= RESET_PC;
      fetch_pc <= RESET_PC;
    end else if (br_flush_i) begin
      pc_q <= br_target_i;
    end else if (issue) begin
      fetch_pc <= pc_q;
      pc_q     <= pc_step(pc_q);
    end
  end

  // One-entry instruction buffer; a refill wins over a same-cycle consume
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_valid <= 1'b0;
      hold_instr <= NOP_INSTR;
      hold_pc    <= 32'd0;
    end else if (br_flush_i) begin
      hold_valid <= 1'b0;
    end else if (refill) begin
      hold_valid <= 1'b1;
      hold_instr <= imem_rdata_i;
      hold_pc    <= fetch_pc;
    end else if (consume) begin
      hold_valid <= 1'b0;
    end
  end

  assign ifid_d.pc    = hold_pc;
  assign ifid_d.instr = hold_instr;
  assign ifid_d.valid = hold_valid;

  ifid_reg #(
    .BUBBLE_INSTR(NOP_INSTR)
  ) u_ifid_reg (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .clear (IFID_clear_i),
    .wren  (IFID_wren_i),
    .d     (ifid_d),
    .q     (ifid_q)
  );

  assign imem_req_o   = issue;
  assign imem_addr_o  = pc_q;
  assign fetch_busy_o = busy;
  assign IFID_pc_o    = ifid_q.pc;
  assign IFID_pc4_o   = pc_step(ifid_q.pc);
  assign IFID_instr_o = ifid_q.instr;
  assign IFID_valid_o = ifid_q.valid;

endmodule

// File: tb/tb_ifu_fetch_stage.sv
// Directed bench for ifu_fetch_stage with a small latency-programmable memory.
module tb_ifu_fetch_stage;

  logic        clk;
  logic        rst_ni;
  logic        pc_wren;
  logic        ifid_wren;
  logic        ifid_clear;
  logic        br_flush;
  logic [31:0] br_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc4;
  logic [31:0] ifid_instr;
  logic        ifid_valid;
  logic        fetch_busy;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          mem_lat  = 1;
  int          mem_cnt;
  int          req_count = 0;
  int          req_snap;
  logic        seen_pc10 = 1'b0;

  ifu_fetch_stage dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .pc_wren_i     (pc_wren),
    .IFID_wren_i   (ifid_wren),
    .IFID_clear_i  (ifid_clear),
    .br_flush_i    (br_flush),
    .br_target_i   (br_target),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .imem_rvalid_i (imem_rvalid),
    .imem_rdata_i  (imem_rdata),
    .IFID_pc_o     (ifid_pc),
    .IFID_pc4_o    (ifid_pc4),
    .IFID_instr_o  (ifid_instr),
    .IFID_valid_o  (ifid_valid),
    .fetch_busy_o  (fetch_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: address 0 holds addi x1,x0,5, the rest a tagged pattern
  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a == 32'd0) ? 32'h0050_0093 : (32'hDEAD_0000 | {16'd0, a[15:0]});
  endfunction

  // Memory model: answer each request after mem_lat cycles
  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      imem_rvalid <= 1'b0;
      imem_rdata  <= 32'd0;
      mem_cnt     <= 0;
    end else begin
      imem_rvalid <= 1'b0;
      if (imem_req) begin
        imem_rdata <= mem_data(imem_addr);
        if (mem_lat <= 1) imem_rvalid <= 1'b1;
        else mem_cnt <= mem_lat - 1;
      end else if (mem_cnt != 0) begin
        mem_cnt <= mem_cnt - 1;
        if (mem_cnt == 1) imem_rvalid <= 1'b1;
      end
    end
  end

  // Monitors: request count and whether the flushed PC ever reached decode
  always @(posedge clk) begin
    if (rst_ni && imem_req) req_count <= req_count + 1;
    if (ifid_valid && ifid_pc == 32'h10) seen_pc10 <= 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni     = 1'b0;
    pc_wren    = 1'b1;
    ifid_wren  = 1'b1;
    ifid_clear = 1'b0;
    br_flush   = 1'b0;
    br_target  = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {31'd0, ifid_valid}, 32'd0);
    check("rst_instr", ifid_instr, 32'h0000_0013);
    check("rst_pc", ifid_pc, 32'd0);
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_busy", {31'd0, fetch_busy}, 32'd0);

    // Reset release: first request at RESET_PC, 1 instruction per 2 cycles
    rst_ni = 1'b1;
    #1;
    check("first_req", {31'd0, imem_req}, 32'd1);
    check("first_addr", imem_addr, 32'h0);
    tick();
    check("wait_busy", {31'd0, fetch_busy}, 32'd1);
    check("wait_noreq", {31'd0, imem_req}, 32'd0);
    tick();
    check("second_req", {31'd0, imem_req}, 32'd1);
    check("second_addr", imem_addr, 32'h4);
    check("ifid_not_yet", {31'd0, ifid_valid}, 32'd0);
    tick();
    check("ifid0_pc", ifid_pc, 32'h0);
    check("ifid0_instr", ifid_instr, 32'h0050_0093);
    check("ifid0_valid", {31'd0, ifid_valid}, 32'd1);
    check("ifid0_pc4", ifid_pc4, 32'h4);
    tick();
    check("gap_bubble", {31'd0, ifid_valid}, 32'd0);
    check("third_addr", imem_addr, 32'h8);
    tick();

    // Stall for 3 cycles while the response for 0x8 arrives
    req_snap  = req_count;
    pc_wren   = 1'b0;
    ifid_wren = 1'b0;
    repeat (3) tick();
    check("stall_noreq", {31'd0, imem_req}, 32'd0);
    check("stall_reqcnt", req_count, req_snap);
    check("stall_pc", ifid_pc, 32'h4);
    check("stall_instr", ifid_instr, 32'hDEAD_0004);
    check("stall_valid", {31'd0, ifid_valid}, 32'd1);
    pc_wren   = 1'b1;
    ifid_wren = 1'b1;
    #1;
    check("release_req", {31'd0, imem_req}, 32'd1);
    check("release_addr", imem_addr, 32'hC);
    tick();
    check("ifid8_pc", ifid_pc, 32'h8);
    check("ifid8_instr", ifid_instr, 32'hDEAD_0008);
    check("ifid8_valid", {31'd0, ifid_valid}, 32'd1);
    tick();
    check("ifid8_once", {31'd0, ifid_valid}, 32'd0);
    check("req10_addr", imem_addr, 32'h10);
    mem_lat = 2;
    tick();
    check("ifidC_pc", ifid_pc, 32'hC);

    // Flush while the 0x10 request is outstanding (no response yet)
    br_flush   = 1'b1;
    br_target  = 32'h100;
    ifid_clear = 1'b1;
    #1;
    check("flush_noreq", {31'd0, imem_req}, 32'd0);
    tick();
    br_flush   = 1'b0;
    ifid_clear = 1'b0;
    #1;
    check("drop_busy", {31'd0, fetch_busy}, 32'd1);
    check("drop_noreq", {31'd0, imem_req}, 32'd0);
    check("clr_valid", {31'd0, ifid_valid}, 32'd0);
    check("clr_instr", ifid_instr, 32'h0000_0013);
    check("clr_pc", ifid_pc, 32'hC);
    tick();
    check("redir_req", {31'd0, imem_req}, 32'd1);
    check("redir_addr", imem_addr, 32'h100);
    mem_lat = 1;
    tick();

    // Flush in the same cycle as the response for 0x100
    br_flush   = 1'b1;
    br_target  = 32'h200;
    ifid_clear = 1'b1;
    tick();
    br_flush   = 1'b0;
    ifid_clear = 1'b0;
    #1;
    check("samecyc_req", {31'd0, imem_req}, 32'd1);
    check("samecyc_addr", imem_addr, 32'h200);
    check("samecyc_idle", {31'd0, fetch_busy}, 32'd0);
    tick();
    check("samecyc_dropped", {31'd0, ifid_valid}, 32'd0);
    tick();

    // Clear together with write: bubble now, buffered 0x200 delivered later
    ifid_clear = 1'b1;
    #1;
    check("clrwr_noreq", {31'd0, imem_req}, 32'd0);
    tick();
    check("clrwr_valid", {31'd0, ifid_valid}, 32'd0);
    check("clrwr_instr", ifid_instr, 32'h0000_0013);
    check("clrwr_pc", ifid_pc, 32'hC);
    ifid_clear = 1'b0;
    #1;
    check("clrwr_req", imem_addr, 32'h204);
    tick();
    check("held_pc", ifid_pc, 32'h200);
    check("held_instr", ifid_instr, 32'hDEAD_0200);
    check("held_valid", {31'd0, ifid_valid}, 32'd1);

    // PC wrap: redirect to the top word, then sequential fetch wraps to 0
    br_flush   = 1'b1;
    br_target  = 32'hFFFF_FFFC;
    ifid_clear = 1'b1;
    tick();
    br_flush   = 1'b0;
    ifid_clear = 1'b0;
    #1;
    check("top_addr", imem_addr, 32'hFFFF_FFFC);
    tick();
    tick();
    check("wrap_req", {31'd0, imem_req}, 32'd1);
    check("wrap_addr", imem_addr, 32'h0);
    tick();
    check("top_ifid_pc", ifid_pc, 32'hFFFF_FFFC);
    check("top_ifid_instr", ifid_instr, 32'hDEAD_FFFC);
    check("top_ifid_pc4", ifid_pc4, 32'h0);
    check("midwait_busy", {31'd0, fetch_busy}, 32'd1);

    // Asynchronous reset in the middle of S_WAIT
    #1;
    rst_ni = 1'b0;
    #1;
    check("arst_valid", {31'd0, ifid_valid}, 32'd0);
    check("arst_instr", ifid_instr, 32'h0000_0013);
    check("arst_pc", ifid_pc, 32'd0);
    check("arst_busy", {31'd0, fetch_busy}, 32'd0);
    check("arst_req", {31'd0, imem_req}, 32'd0);
    tick();

    // Flush during a stall after reset: flush wins, target is fetched next
    pc_wren   = 1'b0;
    br_flush  = 1'b1;
    br_target = 32'h40;
    rst_ni    = 1'b1;
    #1;
    check("flushstall_noreq", {31'd0, imem_req}, 32'd0);
    tick();
    br_flush = 1'b0;
    pc_wren  = 1'b1;
    #1;
    check("flushstall_req", {31'd0, imem_req}, 32'd1);
    check("flushstall_addr", imem_addr, 32'h40);
    check("never_pc10", {31'd0, seen_pc10}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ifu_fetch_stage.md
Name: ifu_fetch_stage

Overview:
- Instruction fetch stage plus the IF/ID pipeline register of the 5-stage core.
- Owns the PC and issues single-outstanding requests to the instruction memory.
- Buffers one returned instruction and loads the IF/ID register under the hazard/flush controls produced by the hazard detection unit: pc_wren, IFID_wren, IFID_clear, br_flush.
- Feeds the decode stage with IFID_pc/instr/valid.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INSTR, 32'h0000_0013, encoding (addi x0,x0,0) inserted for bubbles.

Ports:
- clk_i  input  1  core clock
- rst_ni  input  1  reset, asynchronous, active-low
- pc_wren_i  input  1  from HDU; 0 = stall, no new fetch issued
- IFID_wren_i  input  1  from HDU; 1 = IF/ID register may load
- IFID_clear_i  input  1  from HDU; 1 = IF/ID loads a bubble
- br_flush_i  input  1  redirect request from EX (taken branch/jump)
- br_target_i  input  32  redirect address, valid with br_flush_i
- imem_req_o  output  1  one-cycle request pulse
- imem_addr_o  output  32  request address, valid with imem_req_o
- imem_rvalid_i  input  1  response valid, at least 1 cycle after request
- imem_rdata_i  input  32  response instruction
- IFID_pc_o  output  32  PC of instruction in IF/ID
- IFID_pc4_o  output  32  IFID_pc_o + 4 (combinational from register)
- IFID_instr_o  output  32  instruction in IF/ID
- IFID_valid_o  output  1  1 = IF/ID holds a real instruction
- fetch_busy_o  output  1  1 while a request is outstanding

Behaviour:
- Reset is asynchronous, active-low, and may occur mid-operation. It sets:
  - pc_q = RESET_PC; state = S_IDLE; hold_valid = 0.
  - IFID_valid_o = 0, IFID_instr_o = NOP_INSTR, IFID_pc_o = 0.
  - imem_req_o = 0, fetch_busy_o = 0.
  - Any in-flight response after reset deasserts is the memory's responsibility: it must not return one.
- State machine, 2-bit encoding:
  - S_IDLE: issue when pc_wren_i & !br_flush_i & (!hold_valid | consume). Issue means imem_req_o = 1, imem_addr_o = pc_q, fetch_pc <= pc_q, pc_q <= pc_q + 4, go to S_WAIT.
  - S_WAIT: fetch_busy_o = 1. On imem_rvalid_i: hold_valid <= 1, hold_instr <= imem_rdata_i, hold_pc <= fetch_pc, go to S_IDLE.
  - S_DROP: fetch_busy_o = 1. On imem_rvalid_i, discard the data and go to S_IDLE.
- consume = IFID_wren_i & !IFID_clear_i & hold_valid.
- IF/ID register, priority order:
  1. IFID_clear_i: valid = 0, instr = NOP_INSTR, pc unchanged.
  2. IFID_wren_i: valid <= hold_valid; instr <= hold_valid ? hold_instr : NOP_INSTR; pc <= hold_pc if hold_valid, else unchanged. hold_valid cleared on consume, unless refilled the same cycle.
  3. Otherwise hold all fields.
- br_flush_i (highest priority inside the stage):
  - pc_q <= br_target_i; hold_valid <= 0; no request issued this cycle.
  - S_WAIT without rvalid this cycle → S_DROP.
  - S_WAIT with rvalid this cycle → data discarded, S_IDLE.
  - S_DROP stays S_DROP.
  - IF/ID bubbling is driven by IFID_clear_i; the HDU asserts it with the flush.
- Simultaneous br_flush_i and pc_wren_i = 0: the flush wins and pc_q takes the target.
- Stall (pc_wren_i = 0, IFID_wren_i = 0): no issue. An outstanding response still lands in hold. IF/ID is frozen. No instruction is lost or duplicated.
- Throughput: one instruction per (latency + 1) cycles; with 1-cycle memory latency, 1 instruction per 2 cycles.
- Arithmetic: PC wraps modulo 2^32 (32'hFFFF_FFFC + 4 = 0). br_target_i[1:0] is not checked; it is passed through unmodified.

Decomposition:
- Shared package core_pkg holds:
  - typedef fetch_state_e {S_IDLE, S_WAIT, S_DROP}
  - localparam NOP_INSTR
  - typedef ifid_reg_t {pc, instr, valid}
- Natural sub-module: ifid_reg, the IF/ID register with clear/wren priority, reusable for the other pipeline registers.
- Everything else stays in the top module.

Test Plan:
- Reset release, 1-cycle memory returning 32'h00500093 at 0x0 → imem_req_o at cycle 1 with addr 0x0; IF/ID shows pc = 0x0, instr = 0x00500093, valid = 1 at cycle 3; next request addr 0x4.
- Stall: pc_wren_i = IFID_wren_i = 0 for 3 cycles while the 0x8 response arrives → no new request; IF/ID unchanged; after release IF/ID gets pc 0x8 exactly once.
- Flush while S_WAIT (request 0x10 outstanding), br_target_i = 0x100 → response for 0x10 discarded; next request addr 0x100; IF/ID never shows pc 0x10.
- Flush on the same cycle as imem_rvalid_i → data dropped; state S_IDLE; next request 0x100 on the following cycle.
- IFID_clear_i with IFID_wren_i both 1 → IF/ID valid = 0, instr = 0x00000013; hold retained and loaded on the next wren cycle.
- pc_q = 0xFFFFFFFC fetch → next request addr 0x00000000; rst_ni pulsed low mid-S_WAIT → all outputs return to reset values asynchronously.
